// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load extraction, result selection and a
// retired-instruction counter feeding the register-file write port.
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallW,
    input  logic                 FlushW,
    input  logic                 ValidM,
    input  logic                 RegWriteM,
    input  logic [1:0]           ResultSrcM,
    input  logic [2:0]           Funct3M,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      ReadDataM,
    input  logic [XLEN-1:0]      PCPlus4M,
    input  logic [4:0]           RdM,
    output logic                 RegWriteW,
    output logic [4:0]           RdW,
    output logic [XLEN-1:0]      ResultW,
    output logic                 ValidW,
    output logic                 MisalignW,
    output logic [RET_CNT_W-1:0] InstRetW
);

    logic                 valid_q, valid_d;
    logic                 regwrite_q, regwrite_d;
    logic [1:0]           result_src_q, result_src_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [XLEN-1:0]      alu_result_q, alu_result_d;
    logic [XLEN-1:0]      read_data_q, read_data_d;
    logic [XLEN-1:0]      pc_plus4_q, pc_plus4_d;
    logic [4:0]           rd_q, rd_d;
    logic [RET_CNT_W-1:0] instret_q, instret_d;

    logic [1:0]      off_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic            misalign_s;
    logic [XLEN-1:0] load_data_s;
    logic [XLEN-1:0] result_s;

    // Next-state for the pipeline register: flush beats stall, stall beats capture.
    always_comb begin
        valid_d      = valid_q;
        regwrite_d   = regwrite_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        if (FlushW) begin
            valid_d      = 1'b0;
            regwrite_d   = 1'b0;
            result_src_d = 2'b00;
            funct3_d     = 3'b000;
            alu_result_d = {XLEN{1'b0}};
            read_data_d  = {XLEN{1'b0}};
            pc_plus4_d   = {XLEN{1'b0}};
            rd_d         = 5'd0;
        end else if (StallW) begin
            valid_d      = valid_q;
        end else begin
            valid_d      = ValidM;
            regwrite_d   = RegWriteM;
            result_src_d = ResultSrcM;
            funct3_d     = Funct3M;
            alu_result_d = ALUResultM;
            read_data_d  = ReadDataM;
            pc_plus4_d   = PCPlus4M;
            rd_d         = RdM;
        end
    end

    // Retire the current W instruction unless it is stalled or a faulting load.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !StallW && !misalign_s) begin
            instret_d = instret_q + RET_CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Byte/halfword lane selection from the registered address offset.
    always_comb begin
        off_s  = alu_result_q[1:0];
        byte_s = 8'd0;
        case (off_s)
            2'd0:    byte_s = read_data_q[7:0];
            2'd1:    byte_s = read_data_q[15:8];
            2'd2:    byte_s = read_data_q[23:16];
            2'd3:    byte_s = read_data_q[31:24];
            default: byte_s = 8'd0;
        endcase
        if (off_s[1]) begin
            half_s = read_data_q[31:16];
        end else begin
            half_s = read_data_q[15:0];
        end
    end

    // Alignment/legality check and extension; faulting loads yield zero.
    always_comb begin
        misalign_s  = 1'b0;
        load_data_s = {XLEN{1'b0}};
        case (funct3_q)
            3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_data_s = {24'd0, byte_s};
            3'b001:  begin
                misalign_s  = off_s[0];
                load_data_s = {{16{half_s[15]}}, half_s};
            end
            3'b101:  begin
                misalign_s  = off_s[0];
                load_data_s = {16'd0, half_s};
            end
            3'b010:  begin
                misalign_s  = (off_s != 2'd0);
                load_data_s = read_data_q;
            end
            default: misalign_s = 1'b1;
        endcase
        if (result_src_q != 2'b01) begin
            misalign_s = 1'b0;
        end else if (misalign_s) begin
            load_data_s = {XLEN{1'b0}};
        end else begin
            load_data_s = load_data_s;
        end
    end

    // Writeback source select; the reserved encoding produces zero.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (result_src_q)
            2'b00:   result_s = alu_result_q;
            2'b01:   result_s = load_data_s;
            2'b10:   result_s = pc_plus4_q;
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    assign RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0) & ~misalign_s &
                       (result_src_q != 2'b11);
    assign RdW       = rd_q;
    assign ResultW   = result_s;
    assign ValidW    = valid_q;
    assign MisalignW = misalign_s;
    assign InstRetW  = instret_q;

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            result_src_q <= 2'b00;
            funct3_q     <= 3'b000;
            alu_result_q <= {XLEN{1'b0}};
            read_data_q  <= {XLEN{1'b0}};
            pc_plus4_q   <= {XLEN{1'b0}};
            rd_q         <= 5'd0;
            instret_q    <= {RET_CNT_W{1'b0}};
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            instret_q    <= instret_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage, with a 4-bit-counter twin for wrap checks.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
    logic [4:0]  RdM;

    logic        RegWriteW, ValidW, MisalignW;
    logic [4:0]  RdW;
    logic [31:0] ResultW, InstRetW;

    logic        rw4, v4, mis4;
    logic [4:0]  rd4;
    logic [31:0] res4;
    logic [3:0]  ret4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .RET_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .ValidW(ValidW), .MisalignW(MisalignW),
        .InstRetW(InstRetW)
    );

    writeback_stage #(.XLEN(32), .RET_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteW(rw4), .RdW(rd4),
        .ResultW(res4), .ValidW(v4), .MisalignW(mis4), .InstRetW(ret4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4,
                         input logic [4:0] rd);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3;
        ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; RdM = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rw"},  {31'd0, RegWriteW}, 32'd0);
        chk({tag, "_rd"},  {27'd0, RdW},       32'd0);
        chk({tag, "_res"}, ResultW,            32'd0);
        chk({tag, "_v"},   {31'd0, ValidW},    32'd0);
        chk({tag, "_mis"}, {31'd0, MisalignW}, 32'd0);
        chk({tag, "_ret"}, InstRetW,           32'd0);
    endtask

    initial begin
        reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
        set_m(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
        #1;
        chk_all_zero("reset_init");
        tick(); tick();
        #3 reset = 1'b0;

        // Word load, then byte/halfword extraction from 0x8000F080
        set_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h100, 32'hDEADBEEF, 32'h104, 5'd5);
        tick();
        chk("lw_rw",  {31'd0, RegWriteW}, 32'd1);
        chk("lw_rd",  {27'd0, RdW},       32'd5);
        chk("lw_res", ResultW,            32'hDEADBEEF);
        chk("lw_v",   {31'd0, ValidW},    32'd1);
        chk("lw_ret", InstRetW,           32'd0);

        set_m(1'b1, 1'b1, 2'b01, 3'b000, 32'h100, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lb0", ResultW, 32'hFFFFFF80);
        chk("lw_retired", InstRetW, 32'd1);
        set_m(1'b1, 1'b1, 2'b01, 3'b100, 32'h100, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lbu0", ResultW, 32'h00000080);
        set_m(1'b1, 1'b1, 2'b01, 3'b100, 32'h101, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lbu1", ResultW, 32'h000000F0);
        set_m(1'b1, 1'b1, 2'b01, 3'b001, 32'h102, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lh2", ResultW, 32'hFFFF8000);
        set_m(1'b1, 1'b1, 2'b01, 3'b101, 32'h102, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lhu2", ResultW, 32'h00008000);
        chk("lhu2_mis", {31'd0, MisalignW}, 32'd0);
        chk("ret5", InstRetW, 32'd5);

        // Misaligned loads: no write, zero data, not counted
        set_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h102, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lw_mis",    {31'd0, MisalignW}, 32'd1);
        chk("lw_mis_rw", {31'd0, RegWriteW}, 32'd0);
        chk("lw_mis_res", ResultW, 32'd0);
        chk("ret6", InstRetW, 32'd6);
        set_m(1'b1, 1'b1, 2'b01, 3'b001, 32'h101, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("lh_mis",    {31'd0, MisalignW}, 32'd1);
        chk("lh_mis_rw", {31'd0, RegWriteW}, 32'd0);
        chk("lh_mis_res", ResultW, 32'd0);
        chk("ret_hold_mis", InstRetW, 32'd6);

        // Mux paths, x0 destination, illegal funct3, reserved source
        set_m(1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h44, 5'd1);
        tick();
        chk("pc4_res", ResultW, 32'h44);
        chk("pc4_rw", {31'd0, RegWriteW}, 32'd1);
        chk("ret_hold_mis2", InstRetW, 32'd6);
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'd7, 32'h0, 32'h0, 5'd0);
        tick();
        chk("x0_rw",  {31'd0, RegWriteW}, 32'd0);
        chk("x0_res", ResultW, 32'd7);
        set_m(1'b1, 1'b1, 2'b01, 3'b011, 32'h100, 32'h8000F080, 32'h0, 5'd6);
        tick();
        chk("ill_mis", {31'd0, MisalignW}, 32'd1);
        chk("ill_res", ResultW, 32'd0);
        set_m(1'b1, 1'b1, 2'b11, 3'b000, 32'd5, 32'h0, 32'h0, 5'd3);
        tick();
        chk("rsv_res", ResultW, 32'd0);
        chk("rsv_rw",  {31'd0, RegWriteW}, 32'd0);
        chk("rsv_mis", {31'd0, MisalignW}, 32'd0);
        chk("ret8", InstRetW, 32'd8);

        // Stall for three cycles while M changes
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd7);
        tick();
        chk("pre_stall_res", ResultW, 32'h1234);
        chk("ret9", InstRetW, 32'd9);
        StallW = 1'b1;
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h9999, 32'h0, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_res", ResultW, 32'h1234);
            chk("stall_rd",  {27'd0, RdW}, 32'd7);
            chk("stall_ret", InstRetW, 32'd9);
        end
        StallW = 1'b0;
        tick();
        chk("unstall_res", ResultW, 32'h9999);
        chk("unstall_rd",  {27'd0, RdW}, 32'd9);
        chk("ret10", InstRetW, 32'd10);

        // Flush with stall: bubble enters, stalled instruction not counted
        FlushW = 1'b1; StallW = 1'b1;
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 5'd2);
        tick();
        chk("fs_v",  {31'd0, ValidW},    32'd0);
        chk("fs_rw", {31'd0, RegWriteW}, 32'd0);
        chk("fs_ret", InstRetW, 32'd10);
        FlushW = 1'b0; StallW = 1'b0;
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0, 5'd2);
        tick();
        chk("after_bubble_res", ResultW, 32'h66);
        chk("bubble_not_counted", InstRetW, 32'd10);
        // Flush alone: outgoing W instruction still retires
        FlushW = 1'b1;
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 5'd2);
        tick();
        chk("flush_v", {31'd0, ValidW}, 32'd0);
        chk("flush_ret", InstRetW, 32'd11);
        FlushW = 1'b0;

        // Asynchronous reset mid-operation
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h88, 32'h0, 32'h0, 5'd4);
        tick();
        chk("pre_rst_v", {31'd0, ValidW}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #1 reset = 1'b0;
        set_m(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();

        // Counter wrap on the 4-bit twin
        tick();
        chk("wrap_start", InstRetW, 32'd0);
        set_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 5'd1);
        for (int i = 0; i < 17; i++) tick();
        chk("wrap16_main", InstRetW, 32'd16);
        chk("wrap16_small", {28'd0, ret4}, 32'd0);
        set_m(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("wrap17_main", InstRetW, 32'd17);
        chk("wrap17_small", {28'd0, ret4}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
